// File: rtl/line_window_buf_if.sv
// Pixel-in / column-out bundle for line_window_buf.
// The source side drives the raster pixel stream; the sink side gets registered columns.
interface line_window_buf_if #(
  parameter int NUM_BITS  = 8,
  parameter int NUM_LINES = 3,
  parameter int IMG_W     = 320,
  parameter int IMG_H     = 240
);
  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic                          in_valid;
  logic                          in_sof;
  logic [NUM_BITS-1:0]           in_pix;
  logic                          col_valid;
  logic [NUM_LINES*NUM_BITS-1:0] col_out;
  logic [XW-1:0]                 col_x;
  logic [YW-1:0]                 col_y;
  logic                          frame_done;

  modport master (
    output in_valid, in_sof, in_pix,
    input  col_valid, col_out, col_x, col_y, frame_done
  );

  modport slave (
    input  in_valid, in_sof, in_pix,
    output col_valid, col_out, col_x, col_y, frame_done
  );
endinterface

// File: rtl/line_window_buf.sv
// Multi-line window buffer: per accepted pixel, emits the vertical column of
// NUM_LINES pixels at the same x (current row plus the NUM_LINES-1 rows above).

// One line of delay: a DEPTH-deep shift register that advances only when enabled.
// Left unreset so it maps onto SRL/RAM; stale contents are never exposed as valid.
module line_window_shift_line #(
  parameter int NUM_BITS = 8,
  parameter int DEPTH    = 320
) (
  input  logic                clk,
  input  logic                i_en,
  input  logic [NUM_BITS-1:0] i_pix,
  output logic [NUM_BITS-1:0] o_pix
);
  logic [NUM_BITS-1:0] r_mem [DEPTH];

  // shift one position per stored pixel
  always_ff @(posedge clk) begin
    if (i_en) begin
      r_mem[0] <= i_pix;
      for (int i = 1; i < DEPTH; i++) r_mem[i] <= r_mem[i-1];
    end
  end

  assign o_pix = r_mem[DEPTH-1];
endmodule

module line_window_buf #(
  parameter int NUM_BITS  = 8,
  parameter int NUM_LINES = 3,
  parameter int IMG_W     = 320,
  parameter int IMG_H     = 240
) (
  input  logic             clk,
  input  logic             reset_n,
  line_window_buf_if.slave bus
);
  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int NS = NUM_LINES - 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN} state_t;

  state_t                             r_state, w_state_nxt;
  logic [XW-1:0]                      r_x, w_x_cur, w_x_nxt;
  logic [YW-1:0]                      r_y, w_y_cur, w_y_nxt;
  logic                               w_store, w_emit, w_done;
  logic                               w_last_x, w_fill_end, w_frame_end;

  logic [NUM_BITS-1:0]                w_line_in  [NS];
  logic [NUM_BITS-1:0]                w_line_out [NS];
  logic [NUM_LINES-1:0][NUM_BITS-1:0] w_taps;

  logic                               r_col_valid;
  logic [NUM_LINES*NUM_BITS-1:0]      r_col_out;
  logic [XW-1:0]                      r_col_x;
  logic [YW-1:0]                      r_col_y;
  logic                               r_frame_done;

  // Line k is fed by line k-1, so line k's output is the pixel k+1 rows up at this x.
  for (genvar k = 0; k < NS; k++) begin : g_line
    if (k == 0) begin : g_head
      assign w_line_in[k] = bus.in_pix;
    end else begin : g_chain
      assign w_line_in[k] = w_line_out[k-1];
    end
    line_window_shift_line #(.NUM_BITS(NUM_BITS), .DEPTH(IMG_W)) u_line (
      .clk   (clk),
      .i_en  (w_store),
      .i_pix (w_line_in[k]),
      .o_pix (w_line_out[k])
    );
  end

  // assemble column: tap0 is the incoming pixel, tapk is k rows above
  always_comb begin
    w_taps[0] = bus.in_pix;
    for (int k = 1; k < NUM_LINES; k++) w_taps[k] = w_line_out[k-1];
  end

  // state and position registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
    end
  end

  // next state: a sof pixel always restarts at (0,0); r_x/r_y hold the next expected position
  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_store     = 1'b0;
    w_emit      = 1'b0;
    w_done      = 1'b0;
    w_x_cur     = bus.in_sof ? '0 : r_x;
    w_y_cur     = bus.in_sof ? '0 : r_y;
    w_last_x    = (w_x_cur == XW'(IMG_W - 1));
    w_fill_end  = w_last_x && (w_y_cur == YW'(NUM_LINES - 2));
    w_frame_end = w_last_x && (w_y_cur == YW'(IMG_H - 1));
    if (bus.in_valid) begin
      // in IDLE only a sof pixel is taken; anything else is dropped without shifting
      if (bus.in_sof || (r_state != S_IDLE)) begin
        w_store = 1'b1;
        w_x_nxt = w_last_x ? '0 : w_x_cur + 1'b1;
        w_y_nxt = w_last_x ? w_y_cur + 1'b1 : w_y_cur;
      end
      if (bus.in_sof) begin
        w_state_nxt = w_fill_end ? S_RUN : S_FILL;
      end else begin
        case (r_state)
          S_FILL: if (w_fill_end) w_state_nxt = S_RUN;
          S_RUN: begin
            w_emit = 1'b1;
            if (w_frame_end) begin
              w_done      = 1'b1;
              w_state_nxt = S_IDLE;
              w_x_nxt     = '0;
              w_y_nxt     = '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // registered column outputs; data holds between valid columns
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_col_valid  <= 1'b0;
      r_col_out    <= '0;
      r_col_x      <= '0;
      r_col_y      <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_col_valid  <= w_emit;
      r_frame_done <= w_done;
      if (w_emit) begin
        r_col_out <= w_taps;
        r_col_x   <= w_x_cur;
        r_col_y   <= w_y_cur;
      end
    end
  end

  assign bus.col_valid  = r_col_valid;
  assign bus.col_out    = r_col_out;
  assign bus.col_x      = r_col_x;
  assign bus.col_y      = r_col_y;
  assign bus.frame_done = r_frame_done;
endmodule
